// File: rtl/rp_divider.sv
// -----------------------------------------------------------------------------
// rp_divider
// Iterative unsigned restoring divider, one quotient bit per clock.
// Divides a DIVIDEND_W-bit dividend by a DIVISOR_W-bit divisor. Software
// writes the operands, pulses start and polls busy/done.
//
// Ports
//   Clk          system clock, rising edge
//   Reset_n      synchronous active-low reset
//   ain          dividend
//   bin          divisor in bin[DIVISOR_W-1:0]; upper bits ignored
//   start        request, accepted only while not busy
//   busy         high while an operation is in flight (RUN or ZERO)
//   done         one-cycle pulse, result/remainder valid
//   div_by_zero  last accepted operation had a zero divisor
//   result       quotient (all ones on divide by zero)
//   remainder    remainder (dividend low bits on divide by zero)
// -----------------------------------------------------------------------------
module rp_divider #(
    parameter int DIVIDEND_W = 32,
    parameter int DIVISOR_W  = 16
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic [DIVIDEND_W-1:0] ain,
    input  logic [31:0]           bin,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic [DIVIDEND_W-1:0] result,
    output logic [DIVISOR_W-1:0]  remainder
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_ZERO = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                state_r, state_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s;
    logic [DIVIDEND_W-1:0] quo_r, quo_s;       // dividend shifts out, quotient shifts in
    logic [DIVISOR_W-1:0]  rem_r, rem_s;       // partial remainder, always < divisor
    logic [DIVISOR_W-1:0]  dvs_r, dvs_s;
    logic [DIVIDEND_W-1:0] result_r, result_s;
    logic [DIVISOR_W-1:0]  remainder_r, remainder_s;
    logic                  dbz_r, dbz_s;
    logic                  busy_r, busy_s;
    logic                  done_r, done_s;

    // One restoring step; the shifted remainder needs DIVISOR_W+1 bits so the
    // compare against the divisor cannot overflow.
    logic [DIVISOR_W:0]    shift_s;
    logic [DIVISOR_W:0]    diff_s;
    logic                  fits_s;
    logic [DIVISOR_W-1:0]  rem_step_s;
    logic [DIVIDEND_W-1:0] quo_step_s;
    logic [DIVISOR_W-1:0]  bin_dvs_s;
    logic                  unused_bin_s;

    assign bin_dvs_s    = bin[DIVISOR_W-1:0];
    assign unused_bin_s = ^bin[31:DIVISOR_W];

    // Datapath step of the restoring division.
    always_comb begin
        shift_s    = {rem_r, quo_r[DIVIDEND_W-1]};
        diff_s     = shift_s - {1'b0, dvs_r};
        fits_s     = (shift_s >= {1'b0, dvs_r});
        quo_step_s = {quo_r[DIVIDEND_W-2:0], fits_s};
        if (fits_s) begin
            rem_step_s = diff_s[DIVISOR_W-1:0];
        end else begin
            rem_step_s = shift_s[DIVISOR_W-1:0];
        end
    end

    // Next-state and next-output logic of the control FSM.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        quo_s       = quo_r;
        rem_s       = rem_r;
        dvs_s       = dvs_r;
        result_s    = result_r;
        remainder_s = remainder_r;
        dbz_s       = dbz_r;
        case (state_r)
            S_IDLE, S_DONE: begin
                // DONE accepts a new start directly for back-to-back operation.
                if (start) begin
                    quo_s = ain;
                    rem_s = {DIVISOR_W{1'b0}};
                    dvs_s = bin_dvs_s;
                    cnt_s = CNT_W'(DIVIDEND_W);
                    if (bin_dvs_s == {DIVISOR_W{1'b0}}) begin
                        state_s = S_ZERO;
                    end else begin
                        state_s = S_RUN;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RUN: begin
                quo_s = quo_step_s;
                rem_s = rem_step_s;
                cnt_s = cnt_r - CNT_W'(1);
                // Last iteration: publish the final values straight from the step.
                if (cnt_r == CNT_W'(1)) begin
                    state_s     = S_DONE;
                    result_s    = quo_step_s;
                    remainder_s = rem_step_s;
                    dbz_s       = 1'b0;
                end else begin
                    state_s = S_RUN;
                end
            end
            S_ZERO: begin
                state_s     = S_DONE;
                cnt_s       = {CNT_W{1'b0}};
                result_s    = {DIVIDEND_W{1'b1}};
                remainder_s = quo_r[DIVISOR_W-1:0];
                dbz_s       = 1'b1;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
        busy_s = (state_s == S_RUN) || (state_s == S_ZERO);
        done_s = (state_s == S_DONE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_r     <= S_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            quo_r       <= {DIVIDEND_W{1'b0}};
            rem_r       <= {DIVISOR_W{1'b0}};
            dvs_r       <= {DIVISOR_W{1'b0}};
            result_r    <= {DIVIDEND_W{1'b0}};
            remainder_r <= {DIVISOR_W{1'b0}};
            dbz_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            quo_r       <= quo_s;
            rem_r       <= rem_s;
            dvs_r       <= dvs_s;
            result_r    <= result_s;
            remainder_r <= remainder_s;
            dbz_r       <= dbz_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign div_by_zero = dbz_r;
    assign result      = result_r;
    assign remainder   = remainder_r;

endmodule
